// File: rtl/claw_pkg.sv
// claw_pkg: shared state encoding and direction constants
// for the claw axis sequencer.
package claw_pkg;

    typedef enum logic [1:0] {
        HOME0 = 2'd0,
        HOME1 = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic DIR_HOME = 1'b0;
    localparam logic DIR_AWAY = 1'b1;

endpackage

// File: rtl/claw_axis_channel.sv
// claw_axis_channel: per-axis run latch, limit gating and position
// counter, with a force override used while homing.
module claw_axis_channel
    import claw_pkg::*;
#(
    parameter int POS_W   = 16,
    parameter int MAX_POS = 4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             force_en,
    input  logic             force_dir,
    input  logic             step_tick,
    input  logic             btn_dir,
    input  logic             btn_en,
    input  logic             limit,
    output logic             en,
    output logic             dir,
    output logic [POS_W-1:0] pos
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(MAX_POS);

    logic btn_q;
    logic latch;
    logic rise;
    logic toggled;
    logic at_max;
    logic blocked;
    logic go;

    always_comb begin
        rise    = btn_en & ~btn_q;
        toggled = latch ^ rise;
        at_max  = (pos == POS_MAX);
        blocked = ((btn_dir == DIR_HOME) && limit) ||
                  ((btn_dir == DIR_AWAY) && at_max);
        go      = toggled & ~blocked;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b0;
            latch <= 1'b0;
            en    <= 1'b0;
            dir   <= DIR_HOME;
            pos   <= '0;
        end else begin
            btn_q <= btn_en;
            if (run) begin
                latch <= go;
                en    <= go;
                dir   <= btn_dir;
            end else begin
                latch <= 1'b0;
                en    <= force_en;
                dir   <= force_en ? force_dir : DIR_HOME;
            end
            // The limit switch is the true zero; it beats a coincident step.
            if (limit) begin
                pos <= '0;
            end else if (run && step_tick && en) begin
                if (dir == DIR_AWAY) begin
                    if (!at_max) pos <= pos + 1'b1;
                end else if (pos != '0) begin
                    pos <= pos - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/claw_axis_sequencer.sv
// claw_axis_sequencer: homes both axes, then gates player motion.
// Homing (HOME0/HOME1 and timeout) is built only with CLAW_HOMING_EN.
module claw_axis_sequencer
    import claw_pkg::*;
#(
    parameter int POS_W        = 16,
    parameter int MAX_POS      = 4000,
    parameter int HOME_TIMEOUT = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_tick,
    input  logic [1:0]       btn_dir,
    input  logic [1:0]       btn_en,
    input  logic [1:0]       limit,
    output logic [1:0]       axis_dir,
    output logic [1:0]       axis_en,
    output logic [POS_W-1:0] pos0,
    output logic [POS_W-1:0] pos1,
    output logic             homed,
    output logic             fault
);

    state_t     state;
    state_t     state_next;
    logic [1:0] force_en;
    logic       run;

`ifdef CLAW_HOMING_EN
    localparam int CNT_W = $clog2(HOME_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOME_TIMEOUT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= HOME0;
            cnt     <= '0;
            homed   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            homed   <= (state_next == RUN);
            fault_q <= (state_next == FAULT);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cnt_inc    = cnt + CNT_W'(step_tick);
        unique case (state)
            HOME0: begin
                if (limit[0]) begin
                    state_next = HOME1;
                    cnt_next   = '0;
                end else if (cnt_inc >= CNT_MAX) begin
                    state_next = FAULT;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            HOME1: begin
                if (limit[1]) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else if (cnt_inc >= CNT_MAX) begin
                    state_next = FAULT;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    // Drive from the next state so outputs follow the state on the same edge.
    assign force_en = {state_next == HOME1, state_next == HOME0};
    assign fault    = fault_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            homed <= 1'b1;
        end else begin
            state <= state_next;
            homed <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next = RUN;
    end

    assign force_en = 2'b00;
    assign fault    = 1'b0;
`endif

    assign run = (state == RUN);

    claw_axis_channel #(
        .POS_W   (POS_W),
        .MAX_POS (MAX_POS)
    ) u_axis0 (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .force_en  (force_en[0]),
        .force_dir (DIR_HOME),
        .step_tick (step_tick),
        .btn_dir   (btn_dir[0]),
        .btn_en    (btn_en[0]),
        .limit     (limit[0]),
        .en        (axis_en[0]),
        .dir       (axis_dir[0]),
        .pos       (pos0)
    );

    claw_axis_channel #(
        .POS_W   (POS_W),
        .MAX_POS (MAX_POS)
    ) u_axis1 (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .force_en  (force_en[1]),
        .force_dir (DIR_HOME),
        .step_tick (step_tick),
        .btn_dir   (btn_dir[1]),
        .btn_en    (btn_en[1]),
        .limit     (limit[1]),
        .en        (axis_en[1]),
        .dir       (axis_dir[1]),
        .pos       (pos1)
    );

endmodule

// File: tb/tb_claw_axis_sequencer.sv
// tb_claw_axis_sequencer: directed stimulus against a behavioural
// model of the claw axis sequencer, compared every cycle.
module tb_claw_axis_sequencer;

    localparam int POS_W        = 16;
    localparam int MAX_POS      = 4000;
    localparam int HOME_TIMEOUT = 20000;
`ifdef CLAW_HOMING_EN
    localparam bit HOMING = 1'b1;
`else
    localparam bit HOMING = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             step_tick = 1'b0;
    logic [1:0]       btn_dir = 2'b00;
    logic [1:0]       btn_en = 2'b00;
    logic [1:0]       limit = 2'b00;
    logic [1:0]       axis_dir;
    logic [1:0]       axis_en;
    logic [POS_W-1:0] pos0;
    logic [POS_W-1:0] pos1;
    logic             homed;
    logic             fault;

    claw_axis_sequencer #(
        .POS_W        (POS_W),
        .MAX_POS      (MAX_POS),
        .HOME_TIMEOUT (HOME_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .step_tick (step_tick),
        .btn_dir   (btn_dir),
        .btn_en    (btn_en),
        .limit     (limit),
        .axis_dir  (axis_dir),
        .axis_en   (axis_en),
        .pos0      (pos0),
        .pos1      (pos1),
        .homed     (homed),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int shown  = 0;
    bit cmp_on = 1'b0;

    // Model: mode 0/1 = homing axis 0/1, 2 = run, 3 = fault.
    int         m_mode;
    int         m_cnt;
    int         m_pos [2];
    logic [1:0] m_latch;
    logic [1:0] m_en;
    logic [1:0] m_dir;
    logic [1:0] m_prev;
    logic       m_homed;
    logic       m_fault;

    task automatic model_reset();
        m_mode   = HOMING ? 0 : 2;
        m_cnt    = 0;
        m_pos[0] = 0;
        m_pos[1] = 0;
        m_latch  = 2'b00;
        m_en     = 2'b00;
        m_dir    = 2'b00;
        m_prev   = 2'b00;
        m_homed  = !HOMING;
        m_fault  = 1'b0;
    endtask

    initial model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            int  nxt;
            bit  pressed;
            bit  want;
            bit  stop;
            nxt = m_mode;
            if (m_mode == 2) begin
                for (int i = 0; i < 2; i++) begin
                    pressed = btn_en[i] && !m_prev[i];
                    want    = m_latch[i] ^ pressed;
                    stop    = (btn_dir[i] == 1'b0 && limit[i]) ||
                              (btn_dir[i] == 1'b1 && m_pos[i] == MAX_POS);
                    if (limit[i])
                        m_pos[i] = 0;
                    else if (step_tick && m_en[i] && m_dir[i])
                        m_pos[i] = (m_pos[i] < MAX_POS) ? m_pos[i] + 1 : MAX_POS;
                    else if (step_tick && m_en[i])
                        m_pos[i] = (m_pos[i] > 0) ? m_pos[i] - 1 : 0;
                    m_latch[i] = want && !stop;
                    m_en[i]    = m_latch[i];
                    m_dir[i]   = btn_dir[i];
                end
            end else if (m_mode < 2) begin
                if (limit[m_mode]) begin
                    m_pos[m_mode] = 0;
                    m_cnt = 0;
                    nxt = m_mode + 1;
                end else begin
                    m_cnt = m_cnt + int'(step_tick);
                    if (m_cnt >= HOME_TIMEOUT) nxt = 3;
                end
            end
            m_prev = btn_en;
            if (nxt == 0) begin
                m_en = 2'b01; m_dir = 2'b00;
            end else if (nxt == 1) begin
                m_en = 2'b10; m_dir = 2'b00;
            end else if (nxt == 3 || m_mode != 2) begin
                m_en = 2'b00; m_dir = 2'b00; m_latch = 2'b00;
            end
            m_mode  = nxt;
            m_homed = (nxt == 2);
            m_fault = (nxt == 3);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            checks++;
            if (axis_en === m_en && axis_dir === m_dir &&
                pos0 === POS_W'(m_pos[0]) && pos1 === POS_W'(m_pos[1]) &&
                homed === m_homed && fault === m_fault) begin
                passes++;
            end else if (shown < 20) begin
                shown++;
                $display("FAIL cycle_model t=%0t got en=%b dir=%b p0=%0d p1=%0d h=%b f=%b need en=%b dir=%b p0=%0d p1=%0d h=%b f=%b",
                         $time, axis_en, axis_dir, pos0, pos1, homed, fault,
                         m_en, m_dir, m_pos[0], m_pos[1], m_homed, m_fault);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d need %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step_tick = 1'b1;
            cyc();
            step_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic press(input int i);
        btn_en[i] = 1'b1;
        cyc();
        btn_en[i] = 1'b0;
        cyc();
    endtask

    initial begin
        #1 rst = 1'b1;
        cmp_on = 1'b1;
        repeat (3) cyc();
        check("rst_en", int'(axis_en), 0);
        check("rst_dir", int'(axis_dir), 0);
        check("rst_pos0", int'(pos0), 0);
        check("rst_pos1", int'(pos1), 0);
        check("rst_homed", int'(homed), HOMING ? 0 : 1);
        check("rst_fault", int'(fault), 0);
        rst = 1'b0;
        cyc();
        if (HOMING) begin
            check("home0_en", int'(axis_en), 1);
            ticks(10);
            check("home0_wait", int'(homed), 0);
            limit[0] = 1'b1;
            cyc();
            limit[0] = 1'b0;
            check("home1_en", int'(axis_en), 2);
            ticks(5);
            limit[1] = 1'b1;
            cyc();
            limit[1] = 1'b0;
            check("homed_en", int'(axis_en), 0);
            check("homed_flag", int'(homed), 1);
            check("homed_pos", int'(pos0) + int'(pos1), 0);
        end else begin
            check("run_homed", int'(homed), 1);
            check("run_en", int'(axis_en), 0);
        end
        cyc();

        btn_dir[0] = 1'b1;
        press(0);
        check("a0_on", int'(axis_en[0]), 1);
        ticks(25);
        check("a0_pos25", int'(pos0), 25);
        press(0);
        check("a0_off", int'(axis_en[0]), 0);
        ticks(3);
        check("a0_hold", int'(pos0), 25);

        btn_dir[0] = 1'b0;
        press(0);
        check("a0_dir_home", int'(axis_dir[0]), 0);
        ticks(22);
        check("a0_pos3", int'(pos0), 3);
        step_tick = 1'b1;
        limit[0] = 1'b1;
        cyc();
        step_tick = 1'b0;
        limit[0] = 1'b0;
        check("a0_resync", int'(pos0), 0);
        check("a0_autostop", int'(axis_en[0]), 0);
        cyc();
        press(0);
        check("a0_on_zero", int'(axis_en[0]), 1);
        ticks(2);
        check("a0_sat0", int'(pos0), 0);
        press(0);

        btn_dir[1] = 1'b1;
        press(1);
        ticks(3999);
        check("a1_pos3999", int'(pos1), 3999);
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        check("a1_max", int'(pos1), MAX_POS);
        check("a1_en_at_max", int'(axis_en[1]), 1);
        cyc();
        check("a1_stop", int'(axis_en[1]), 0);
        ticks(3);
        check("a1_hold_max", int'(pos1), MAX_POS);
        press(1);
        check("a1_blocked", int'(axis_en[1]), 0);
        btn_dir[1] = 1'b0;
        press(1);
        check("a1_back_on", int'(axis_en[1]), 1);
        ticks(1);
        check("a1_pos3999b", int'(pos1), 3999);

        btn_dir[0] = 1'b1;
        press(0);
        ticks(5);
        check("both_pos0", int'(pos0), 5);
        check("both_pos1", int'(pos1), 3994);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_en", int'(axis_en), 0);
        check("mid_rst_dir", int'(axis_dir), 0);
        check("mid_rst_pos", int'(pos0) + int'(pos1), 0);
        check("mid_rst_homed", int'(homed), HOMING ? 0 : 1);
        @(posedge clk);
        #1 rst = 1'b0;
        btn_dir = 2'b00;
        cyc();
        if (HOMING) begin
            check("restart_home0", int'(axis_en), 1);
            ticks(HOME_TIMEOUT - 1);
            check("pre_timeout", int'(fault), 0);
            ticks(1);
            check("timeout_fault", int'(fault), 1);
            check("timeout_en", int'(axis_en), 0);
            btn_dir = 2'b11;
            press(0);
            press(1);
            ticks(3);
            check("fault_stuck", int'(fault), 1);
            check("fault_en", int'(axis_en), 0);
        end else begin
            check("restart_homed", int'(homed), 1);
            check("restart_en", int'(axis_en), 0);
        end
        cyc();
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/claw_axis_sequencer.md
# claw_axis_sequencer

Motion controller for the claw game's two stepper axes. It sits between the debounced button/limit inputs and the two PmodSTEP drivers. After reset it homes both axes against their limit switches, then converts the direction buttons and the toggle-lock enable buttons into gated `dir`/`en` pairs for the drivers. It also tracks each axis position in steps and enforces the home limit and a soft far-end limit.

## Interface
Parameters:
- `POS_W`, 16: width of each position counter.
- `MAX_POS`, 4000: soft far-end limit in steps; must be less than 2^POS_W.
- `HOME_TIMEOUT`, 20000: maximum step ticks allowed per homing axis before fault.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `step_tick`  in  1  one-`clk`-wide pulse at the motor step rate, produced by the clock divider.
- `btn_dir`  in  2  debounced direction level per axis: 0 = toward home, 1 = away.
- `btn_en`  in  2  debounced enable button per axis; a rising edge toggles the run latch.
- `limit`  in  2  debounced home limit switch per axis; 1 = switch closed.
- `axis_dir`  out  2  direction to each driver.
- `axis_en`  out  2  enable to each driver.
- `pos0`, `pos1`  out  POS_W  axis position in steps; 0 = home.
- `homed`  out  1  high while in RUN.
- `fault`  out  1  high while in FAULT.

## Operation
State machine states: HOME0, HOME1, RUN, FAULT.

Reset values:
- State = HOME0.
- `axis_en`=00, `axis_dir`=00.
- `pos0`=`pos1`=0.
- `homed`=0, `fault`=0.
- Run latches = 0.
- Edge registers = 0.
- Timeout counter = 0.

HOME0:
- `axis_en[0]`=1, `axis_dir[0]`=0; axis 1 disabled.
- Each `step_tick` increments the timeout counter.
- `limit[0]`=1 → `pos0`←0, counter←0, go to HOME1.
- Counter reaches HOME_TIMEOUT → go to FAULT.
- Homing starts immediately; a `limit[0]` already high at entry exits on the first cycle.

HOME1:
- Same as HOME0 for axis 1 using `limit[1]`.
- On limit hit → go to RUN.

RUN, per axis:
- Rising edge of `btn_en[i]` toggles run latch i.
- `axis_dir[i]` = `btn_dir[i]`.
- `axis_en[i]` = latch AND NOT(dir=0 AND `limit[i]`) AND NOT(dir=1 AND pos=MAX_POS).
- When the gate blocks an enabled latch, the latch clears (auto-stop). The player must press again.
- Position update on `step_tick` with `axis_en[i]`=1:
  - dir=1: pos+1.
  - dir=0: pos−1, saturating at 0.
- `limit[i]`=1 in RUN forces pos←0 (re-sync).
- Simultaneous `step_tick` and limit: the limit wins and no count occurs.

FAULT:
- All `en` low; `fault`=1.
- Exits only via `rst`.

Edge registers track `btn_en` in every state. A button held while entering RUN does not cause a toggle.

## Timing
- All outputs are registered.
- Input event → `axis_en`/`axis_dir`/state change occurs on the next `clk` edge (1-cycle latency).
- A position updates on the same edge that samples `step_tick`.
- A direction change while enabled takes effect next cycle. There is no dead time; the driver state machines tolerate this.
- An asserted `rst` at any time asynchronously forces the reset values. Homing restarts on deassertion.

## Configuration
- `CLAW_HOMING_EN` defined:
  - Homing runs as above; reset state is HOME0.
- `CLAW_HOMING_EN` not defined:
  - HOME0, HOME1 and the timeout counter are compiled out.
  - Reset state is RUN, with `homed`=1 after reset and positions starting at 0.
  - `fault` is tied 0.
  - Limit gating and re-sync remain active.

## Structure
- Package `claw_pkg` holds:
  - State enum: HOME0=2'd0, HOME1=2'd1, RUN=2'd2, FAULT=2'd3.
  - Constants DIR_HOME=1'b0, DIR_AWAY=1'b1.
- Sub-module `claw_axis_channel`, instantiated twice, contains:
  - Edge detect, run latch, gating, and the saturating position counter.
  - A `force_en`/`force_dir` override, used by the parent during homing.
- The parent holds the state machine and the timeout counter.

## Test plan
- Reset, `limit[0]` rises after 10 ticks, `limit[1]` after 5 more → `axis_en` goes 01 → 10 → 00. `homed`=1 one cycle after `limit[1]`; `pos0`=`pos1`=0.
- Homing with no limit for 20000 ticks → `fault`=1 and `axis_en`=00. Inputs are then ignored until `rst`.
- RUN, `btn_dir[0]`=1, pulse `btn_en[0]`, then 25 ticks → `pos0`=25. A second `btn_en[0]` pulse gives `axis_en[0]`=0 and `pos0` holds.
- RUN, axis 1 with dir=1 and latch on, driven to MAX_POS → `axis_en[1]`=0 the cycle after `pos1`=4000, latch cleared. Further ticks leave `pos1`=4000.
- RUN, dir=0 at `pos0`=3, `limit[0]` asserted together with `step_tick` → `pos0`=0 with no decrement; `axis_en[0]`=0 and the latch clears.
- Assert `rst` mid-RUN with both axes moving → all outputs return to reset values immediately, and HOME0 restarts after release.
